// File: rtl/ervp_lock_arbiter.sv
// Hardware-lock arbiter: serves one acquire/release per cycle in round-robin order
// over NUM_REQ requesters, tracks per-lock owners and optionally force-releases stale locks.
module ervp_lock_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned NUM_LOCK      = 8,
    parameter int unsigned BW_LOCK_INDEX = 3,
    parameter int unsigned BW_REQ_INDEX  = 2,
    parameter int unsigned HOLD_LIMIT    = 0,
    parameter int unsigned BW_HOLD       = 16
) (
    input  logic                              clk,
    input  logic                              rstnn,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_release,
    input  logic [NUM_REQ*BW_LOCK_INDEX-1:0]  req_lock_index,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                req_result,
    input  logic [NUM_LOCK-1:0]               clear_timeout,
    output logic [NUM_LOCK-1:0]               lock_status_list,
    output logic [NUM_LOCK*BW_REQ_INDEX-1:0]  lock_owner_list,
    output logic [NUM_LOCK-1:0]               timeout_flag
);

    localparam int unsigned BW_SUM = BW_REQ_INDEX + 1;
    localparam logic [BW_HOLD-1:0] HOLD_LAST =
        (HOLD_LIMIT == 0) ? '0 : BW_HOLD'(HOLD_LIMIT - 1);

    logic [NUM_REQ-1:0]       r_ready, r_result;
    logic [NUM_LOCK-1:0]      r_status, r_flag;
    logic [BW_REQ_INDEX-1:0]  r_owner [NUM_LOCK];
    logic [BW_HOLD-1:0]       r_hold  [NUM_LOCK];
    logic [BW_REQ_INDEX-1:0]  r_rr_ptr;

    logic [NUM_REQ-1:0]       w_eligible;
    logic [2*NUM_REQ-1:0]     w_rot;
    logic [BW_SUM-1:0]        w_sum;
    logic                     w_grant;
    logic [BW_REQ_INDEX-1:0]  w_grant_id;
    logic                     w_sel_release;
    logic [BW_LOCK_INDEX-1:0] w_sel_index;
    logic                     w_grant_result;
    logic [BW_REQ_INDEX-1:0]  w_ptr_next;

    logic [NUM_REQ-1:0]       w_ready, w_result;
    logic [NUM_LOCK-1:0]      w_status, w_flag;
    logic [BW_REQ_INDEX-1:0]  w_owner [NUM_LOCK];
    logic [BW_HOLD-1:0]       w_hold  [NUM_LOCK];

    // Acknowledged requesters are masked so a dropping valid is not served twice.
    assign w_eligible = req_valid & ~r_ready;

    // Round-robin pick: rotate so the search start sits at bit 0, take the first set bit.
    always_comb begin
        w_grant       = 1'b0;
        w_sum         = '0;
        w_grant_id    = '0;
        w_sel_release = 1'b0;
        w_sel_index   = '0;
        w_rot         = {w_eligible, w_eligible} >> r_rr_ptr;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_grant && w_rot[k]) begin
                w_grant = 1'b1;
                w_sum   = BW_SUM'(r_rr_ptr) + BW_SUM'(k);
            end
        end
        if (w_sum >= BW_SUM'(NUM_REQ)) begin
            w_sum = w_sum - BW_SUM'(NUM_REQ);
        end
        w_grant_id = w_sum[BW_REQ_INDEX-1:0];
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (BW_REQ_INDEX'(i) == w_grant_id) begin
                w_sel_release = req_release[i];
                w_sel_index   = req_lock_index[i*BW_LOCK_INDEX +: BW_LOCK_INDEX];
            end
        end
        w_ptr_next = (w_grant_id == BW_REQ_INDEX'(NUM_REQ - 1)) ? '0
                   : w_grant_id + BW_REQ_INDEX'(1);
    end

    // Next lock state: hold timer first, then the granted request may override it.
    always_comb begin
        w_status       = r_status;
        w_flag         = r_flag & ~clear_timeout;
        w_ready        = '0;
        w_result       = '0;
        w_grant_result = 1'b0;
        for (int unsigned l = 0; l < NUM_LOCK; l++) begin
            w_owner[l] = r_owner[l];
            w_hold[l]  = '0;
        end

        if (HOLD_LIMIT != 0) begin
            for (int unsigned l = 0; l < NUM_LOCK; l++) begin
                if (r_status[l]) begin
                    w_hold[l] = r_hold[l] + BW_HOLD'(1);
                    if (r_hold[l] == HOLD_LAST) begin
                        w_status[l] = 1'b0;
                        w_owner[l]  = '0;
                        w_hold[l]   = '0;
                        w_flag[l]   = 1'b1;
                    end
                end
            end
        end

        // Decisions use the current-cycle state, so an expiring lock still reads as held.
        for (int unsigned l = 0; l < NUM_LOCK; l++) begin
            if (w_grant && (BW_LOCK_INDEX'(l) == w_sel_index)) begin
                if (w_sel_release) begin
                    if (r_status[l] && (r_owner[l] == w_grant_id)) begin
                        w_grant_result = 1'b1;
                        w_status[l]    = 1'b0;
                        w_owner[l]     = '0;
                        w_hold[l]      = '0;
                        w_flag[l]      = r_flag[l] & ~clear_timeout[l];
                    end
                end else if (!r_status[l]) begin
                    w_grant_result = 1'b1;
                    w_status[l]    = 1'b1;
                    w_owner[l]     = w_grant_id;
                    w_hold[l]      = '0;
                end
            end
        end

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_ready[i]  = w_grant && (BW_REQ_INDEX'(i) == w_grant_id);
            w_result[i] = w_ready[i] && w_grant_result;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_ready  <= '0;
            r_result <= '0;
            r_status <= '0;
            r_flag   <= '0;
            r_rr_ptr <= '0;
            for (int unsigned l = 0; l < NUM_LOCK; l++) begin
                r_owner[l] <= '0;
                r_hold[l]  <= '0;
            end
        end else begin
            r_ready  <= w_ready;
            r_result <= w_result;
            r_status <= w_status;
            r_flag   <= w_flag;
            if (w_grant) begin
                r_rr_ptr <= w_ptr_next;
            end
            for (int unsigned l = 0; l < NUM_LOCK; l++) begin
                r_owner[l] <= w_owner[l];
                r_hold[l]  <= w_hold[l];
            end
        end
    end

    assign req_ready        = r_ready;
    assign req_result       = r_result;
    assign lock_status_list = r_status;
    assign timeout_flag     = r_flag;

    for (genvar l = 0; l < NUM_LOCK; l++) begin : g_owner
        assign lock_owner_list[l*BW_REQ_INDEX +: BW_REQ_INDEX] = r_owner[l];
    end

endmodule
